reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Single-domain controller that orders reset release for the design's clock domains/subsystems after PLL lock.
- Filters PLL lock, releases N stage resets one at a time with fixed spacing, and re-sequences on lock loss or a soft-reset request.
- Outputs are registered in clk. Each consuming domain feeds its stage bit through its own async-assert/sync-deassert reset synchronizer.

Parameters:
N_STAGES, 4, number of ordered reset outputs (2..8)
STAGE_DLY, 256, clk cycles between successive stage releases (>=2)
LOCK_FILTER, 16, consecutive synchronized-lock cycles required before sequencing (>=2)
SOFT_HOLD, 64, clk cycles all outputs are held asserted after a soft request (>=2)

Ports:
clk  in  1  free-running system clock
nRST  in  1  reset, asynchronous, active-low
pll_locked  in  1  asynchronous PLL lock; 2-flop synchronized internally (locked_s)
soft_rst_req  in  1  synchronous single-cycle soft-reset request
rst_n_out  out  N_STAGES  per-stage reset, active-low; bit 0 is released first
seq_done  out  1  high while all stages are released (RUN)
busy  out  1  high in every state except RUN
lock_lost_cnt  out  8  saturating count of lock losses seen in RELEASE/RUN

Behaviour:
- Reset (nRST low, asynchronous): rst_n_out=0, seq_done=0, busy=1, lock_lost_cnt=0, state=WAIT_LOCK, all counters=0, sync flops=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: WAIT_LOCK, RELEASE, RUN, SOFT_HOLD.
- WAIT_LOCK:
  - lock_cnt increments while locked_s=1 and clears to 0 on locked_s=0.
  - Transition to RELEASE happens on the edge where locked_s=1 and lock_cnt==LOCK_FILTER-1. Call that edge E0. Set stage_idx=0, dly_cnt=0.
  - soft_rst_req is ignored.
- RELEASE:
  - dly_cnt increments each cycle.
  - On dly_cnt==STAGE_DLY-1: set rst_n_out[stage_idx]=1, clear dly_cnt, increment stage_idx.
  - Stage k therefore rises on edge E0+(k+1)*STAGE_DLY.
  - When the last stage is released: on the same edge, state=RUN, seq_done=1, busy=0.
  - Released bits stay high until an abort.
- RUN: hold all outputs.
- Abort on lock loss (locked_s=0 in RELEASE or RUN):
  - Next edge: rst_n_out=all 0, seq_done=0, busy=1, lock_lost_cnt+=1 (saturates at 255).
  - state=WAIT_LOCK, counters cleared.
- Abort on soft request (soft_rst_req=1 in RELEASE or RUN, with locked_s=1):
  - Next edge: rst_n_out=all 0, seq_done=0, busy=1, hold_cnt=0, state=SOFT_HOLD.
  - lock_lost_cnt is unchanged.
- Simultaneous lock loss and soft request: lock loss wins (WAIT_LOCK, count increments).
- SOFT_HOLD:
  - hold_cnt increments; on hold_cnt==SOFT_HOLD-1, state=WAIT_LOCK with lock_cnt=0. Lock is always re-filtered.
  - A repeated soft_rst_req restarts hold_cnt at 0.
  - Lock loss here is not counted; the lock filter in WAIT_LOCK handles it.
- All outputs drop together on any abort; there is no reverse-order assertion.
- nRST assertion mid-sequence returns immediately to reset values. lock_lost_cnt is cleared only by nRST.
- Counter widths: $clog2 of each max value; stage_idx is $clog2(N_STAGES)+1 bits. No wrap is possible because every counter is compared and cleared.

Decomposition:
- Package reset_seq_pkg holds:
  - typedef enum logic [1:0] seq_state_t {WAIT_LOCK, RELEASE, RUN, SOFT_HOLD};
  - localparam LOCK_CNT_MAX = 8'hFF.
- One sub-module, sync_2ff: a generic 2-flop bit synchronizer with async active-low clear, used for pll_locked.
- The FSM and counters stay in reset_sequencer.

Test Plan (N_STAGES=4, STAGE_DLY=8, LOCK_FILTER=4, SOFT_HOLD=5):
1. nRST released, pll_locked=1 constant -> E0 is the 4th edge with locked_s=1; rst_n_out goes 0001/0011/0111/1111 at E0+8/+16/+24/+32; seq_done=1 and busy=0 at E0+32.
2. pll_locked toggles low for 1 cycle after 3 locked_s-high cycles -> no transition; lock_cnt restarts; E0 occurs only after 4 further consecutive high cycles.
3. In RUN, drop pll_locked -> 3 edges later (2 sync + 1) rst_n_out=0000, seq_done=0, lock_lost_cnt=1; re-raise lock -> full sequence repeats with identical spacing.
4. In RELEASE with rst_n_out=0011, pulse soft_rst_req -> next edge rst_n_out=0000; SOFT_HOLD for 5 cycles, then WAIT_LOCK; with lock held, E0 comes 4 cycles later and the sequence restarts from stage 0; lock_lost_cnt unchanged.
5. soft_rst_req asserted in the same cycle locked_s falls (in RUN) -> WAIT_LOCK (not SOFT_HOLD); lock_lost_cnt increments.
6. Force 300 lock losses -> lock_lost_cnt saturates at 255. Pulse nRST low mid-RELEASE -> all outputs immediately 0 and lock_lost_cnt=0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
//   Shared types and constants for the reset sequencer.
//   - seq_state_t  : sequencer FSM states
//   - LOCK_CNT_MAX : saturation value of the lock-loss counter
//   - sat_inc8     : saturating 8-bit increment used by the lock-loss counter
// ---------------------------------------------------------------------------
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        SOFT_HOLD = 2'd3
    } seq_state_t;

    localparam logic [7:0] LOCK_CNT_MAX = 8'hFF;

    // Increment that sticks at LOCK_CNT_MAX so a flapping PLL can never
    // wrap the diagnostic count back to a small, reassuring number.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == LOCK_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Generic two-flop single-bit synchronizer with asynchronous active-low
//   clear. Both flops clear to 0, so a cleared synchronizer always reports
//   "not asserted" until the input has been seen for two clk edges.
//
// Ports
//   clk  : destination clock
//   nRST : asynchronous active-low clear
//   d_i  : asynchronous input bit
//   q_o  : synchronized output bit (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic nRST,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//   Orders reset release for the downstream clock domains once the PLL is
//   stably locked. The synchronized lock must be seen for LOCK_FILTER
//   consecutive cycles, after which stage resets are released one at a time,
//   bit 0 first, every STAGE_DLY cycles. Losing lock or a soft-reset request
//   drops every stage together and starts over; soft requests additionally
//   hold everything in reset for SOFT_HOLD cycles before re-filtering lock.
//   All outputs come straight from flops, so consumers can feed them into
//   their own async-assert/sync-deassert reset synchronizers.
//
// Ports
//   clk           : free-running system clock
//   nRST          : asynchronous active-low reset
//   pll_locked    : asynchronous PLL lock indication (synchronized here)
//   soft_rst_req  : synchronous single-cycle soft-reset request
//   rst_n_out     : per-stage active-low resets, bit 0 released first
//   seq_done      : high while every stage is released
//   busy          : high whenever the sequencer is not in RUN
//   lock_lost_cnt : saturating count of lock losses during RELEASE/RUN
// ---------------------------------------------------------------------------
module reset_sequencer #(
    parameter int N_STAGES    = 4,
    parameter int STAGE_DLY   = 256,
    parameter int LOCK_FILTER = 16,
    parameter int SOFT_HOLD   = 64
) (
    input  logic                clk,
    input  logic                nRST,
    input  logic                pll_locked,
    input  logic                soft_rst_req,
    output logic [N_STAGES-1:0] rst_n_out,
    output logic                seq_done,
    output logic                busy,
    output logic [7:0]          lock_lost_cnt
);

    import reset_seq_pkg::*;

    // Each counter is sized for its largest compared value; every counter is
    // cleared when it reaches that value, so none of them can wrap.
    localparam int LW = $clog2(LOCK_FILTER);
    localparam int DW = $clog2(STAGE_DLY);
    localparam int HW = $clog2(SOFT_HOLD);
    localparam int SW = $clog2(N_STAGES) + 1;

    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_FILTER - 1);
    localparam logic [DW-1:0] DLY_LAST   = DW'(STAGE_DLY - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(SOFT_HOLD - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(N_STAGES - 1);

    logic                locked_s;

    seq_state_t          state_q;
    logic [LW-1:0]       lock_cnt_q;
    logic [DW-1:0]       dly_cnt_q;
    logic [HW-1:0]       hold_cnt_q;
    logic [SW-1:0]       stage_idx_q;
    logic [N_STAGES-1:0] rst_n_out_q;
    logic                seq_done_q;
    logic                busy_q;
    logic [7:0]          lock_lost_cnt_q;

    sync_2ff u_lock_sync (
        .clk  (clk),
        .nRST (nRST),
        .d_i  (pll_locked),
        .q_o  (locked_s)
    );

    // Sequencer FSM with all outputs registered alongside the state.
    // Abort priority in RELEASE/RUN: lock loss, then soft request, then
    // normal progress. Released stages always form a contiguous run of ones
    // from bit 0, so releasing the next stage is a shift-in of a one.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q         <= WAIT_LOCK;
            lock_cnt_q      <= '0;
            dly_cnt_q       <= '0;
            hold_cnt_q      <= '0;
            stage_idx_q     <= '0;
            rst_n_out_q     <= '0;
            seq_done_q      <= 1'b0;
            busy_q          <= 1'b1;
            lock_lost_cnt_q <= '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        if (lock_cnt_q == LOCK_LAST) begin
                            state_q     <= RELEASE;
                            lock_cnt_q  <= '0;
                            stage_idx_q <= '0;
                            dly_cnt_q   <= '0;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + LW'(1);
                        end
                    end else begin
                        lock_cnt_q <= '0;
                    end
                end

                RELEASE, RUN: begin
                    if (!locked_s) begin
                        state_q         <= WAIT_LOCK;
                        rst_n_out_q     <= '0;
                        seq_done_q      <= 1'b0;
                        busy_q          <= 1'b1;
                        lock_cnt_q      <= '0;
                        dly_cnt_q       <= '0;
                        hold_cnt_q      <= '0;
                        stage_idx_q     <= '0;
                        lock_lost_cnt_q <= sat_inc8(lock_lost_cnt_q);
                    end else if (soft_rst_req) begin
                        state_q     <= reset_seq_pkg::SOFT_HOLD;
                        rst_n_out_q <= '0;
                        seq_done_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        lock_cnt_q  <= '0;
                        dly_cnt_q   <= '0;
                        hold_cnt_q  <= '0;
                        stage_idx_q <= '0;
                    end else if (state_q == RELEASE) begin
                        if (dly_cnt_q == DLY_LAST) begin
                            rst_n_out_q <= {rst_n_out_q[N_STAGES-2:0], 1'b1};
                            dly_cnt_q   <= '0;
                            stage_idx_q <= stage_idx_q + SW'(1);
                            if (stage_idx_q == STAGE_LAST) begin
                                state_q    <= RUN;
                                seq_done_q <= 1'b1;
                                busy_q     <= 1'b0;
                            end
                        end else begin
                            dly_cnt_q <= dly_cnt_q + DW'(1);
                        end
                    end
                end

                reset_seq_pkg::SOFT_HOLD: begin
                    // Lock state is ignored here; WAIT_LOCK always
                    // re-filters lock from zero afterwards.
                    if (soft_rst_req) begin
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= WAIT_LOCK;
                        hold_cnt_q <= '0;
                        lock_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end

                default: begin
                    state_q     <= WAIT_LOCK;
                    rst_n_out_q <= '0;
                    seq_done_q  <= 1'b0;
                    busy_q      <= 1'b1;
                    lock_cnt_q  <= '0;
                    dly_cnt_q   <= '0;
                    hold_cnt_q  <= '0;
                    stage_idx_q <= '0;
                end
            endcase
        end
    end

    assign rst_n_out     = rst_n_out_q;
    assign seq_done      = seq_done_q;
    assign busy          = busy_q;
    assign lock_lost_cnt = lock_lost_cnt_q;

endmodule
